serializador_tx: RTL and testbench
==================================

SERIALIZADOR_TX -- requirements
Module: serializador_tx

Interface
REQ-001 Parameter: COM_CHAR, 8'hBC, sync comma byte sent during SYNC.
REQ-002 Parameter: IDLE_CHAR, 8'h7C, filler byte sent in ACTIVE when no data is offered.
REQ-003 Parameter: SYNC_COUNT, 4, number of COM_CHAR frames sent before ACTIVE (range 1..15).
REQ-004 Port: clk_8f  in  1  bit clock; all logic on its rising edge.
REQ-005 Port: reset  in  1  reset, synchronous, active-low.
REQ-006 Port: data_in  in  8  parallel byte from upstream.
REQ-007 Port: valid_in  in  1  data_in holds a byte to send.
REQ-008 Port: data_out  out  1  serial bit stream, MSB first.
REQ-009 Port: ready_out  out  1  one-cycle pulse: data_in consumed this edge.
REQ-010 Port: active  out  1  high while in ACTIVE state.

Function
REQ-011 Block SHALL use states SYNC and ACTIVE, a frame bit counter bit_cnt, an 8-bit shift register and a sync frame counter; all outputs registered.
REQ-012 Frame length SHALL be 8 clk_8f cycles (9 with parity, REQ-024); frames SHALL be contiguous, no gap cycles.
REQ-013 On a frame-start edge (bit_cnt==0): select byte B, data_out<=B[7], shift register<=B<<1, bit_cnt<=1.
REQ-014 On other edges: data_out<=shift register[7], shift left, bit_cnt increments, wrapping to 0 after the last frame bit.
REQ-015 In SYNC, B SHALL be COM_CHAR regardless of valid_in; sync counter increments each frame start.
REQ-016 On the frame-start edge after SYNC_COUNT COM frames completed, state SHALL become ACTIVE and active<=1 on that edge; byte selection on that edge already follows ACTIVE rules.
REQ-017 In ACTIVE, B SHALL be data_in if valid_in==1, else IDLE_CHAR.
REQ-018 data_in/valid_in SHALL be sampled only on frame-start edges; ready_out<=1 exactly on frame-start edges in ACTIVE with valid_in==1, else 0.
REQ-019 valid_in held high SHALL yield one accepted byte per frame (back-to-back, ready_out every 8 cycles).
REQ-020 ACTIVE SHALL persist until reset; no return to SYNC otherwise.

Reset
REQ-021 While reset==0 on an edge: data_out=0, ready_out=0, active=0, bit_cnt=0, shift register=0, sync counter=0, state=SYNC.
REQ-022 Reset asserted mid-frame SHALL abort the frame on that edge; first edge with reset==1 SHALL be a frame start emitting COM_CHAR[7].
REQ-023 First serial bit SHALL appear on data_out one edge after reset release (latency 1).

Configuration
REQ-024 Macro SERIAL_PARITY_EN defined: each frame appends a 9th bit, even parity (XOR of B's 8 bits), frame length 9, ready_out every 9 cycles when streaming.
REQ-025 Macro SERIAL_PARITY_EN undefined: frames are 8 bits, no parity logic present.

Verification
REQ-026 reset=0 for 5 edges, valid_in=1 -> data_out=0, ready_out=0, active=0 throughout.
REQ-027 Release reset, valid_in=0, SYNC_COUNT=4 -> first 32 bits = 10111100 x4, active rises at edge 33, then 01111100 repeated.
REQ-028 In ACTIVE, data_in=0xA5 valid_in=1 for one frame start -> ready_out single pulse, next 8 bits 10100101, then IDLE_CHAR.
REQ-029 valid_in=1 with 0x01 then 0xFF on consecutive frame starts -> 00000001 11111111 with no gap, ready_out pulses 8 cycles apart.
REQ-030 reset=0 for one edge at bit_cnt==4 of an ACTIVE frame -> data_out=0, active=0 that edge; after release, 4 COM frames restart.
REQ-031 SERIAL_PARITY_EN defined, data 0xA5 then 0x01 -> 101001010 then 000000011.

Source files
------------

// File: rtl/serializador_tx.sv
// serializador_tx: byte-to-serial transmitter, MSB first, with a COM_CHAR sync preamble before ACTIVE.
// Optional macro SERIAL_PARITY_EN appends an even-parity bit to every frame (9-bit frames).
module serializador_tx #(
    parameter logic [7:0]  COM_CHAR   = 8'hBC,
    parameter logic [7:0]  IDLE_CHAR  = 8'h7C,
    parameter int unsigned SYNC_COUNT = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       data_out,
    output logic       ready_out,
    output logic       active
);

`ifdef SERIAL_PARITY_EN
    localparam int unsigned FRAME_LEN = 9;
`else
    localparam int unsigned FRAME_LEN = 8;
`endif
    localparam int unsigned    CNT_W    = 4;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] SYNC_LIM = CNT_W'(SYNC_COUNT);

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] r_sync_cnt;
    logic [7:0]       r_shift;
    logic             r_data_out;
    logic             r_ready;
    logic             r_active;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_bit_cnt_nxt;
    logic [CNT_W-1:0] w_sync_cnt_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_data_out_nxt;
    logic             w_ready_nxt;
    logic [7:0]       w_byte;

`ifdef SERIAL_PARITY_EN
    logic r_parity;
    logic w_parity_nxt;
`endif

    // State and output registers; synchronous active-low reset aborts any frame in progress.
    always_ff @(posedge clk_8f) begin
        if (!reset) begin
            r_state    <= ST_SYNC;
            r_bit_cnt  <= '0;
            r_sync_cnt <= '0;
            r_shift    <= '0;
            r_data_out <= 1'b0;
            r_ready    <= 1'b0;
            r_active   <= 1'b0;
`ifdef SERIAL_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_sync_cnt <= w_sync_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_data_out <= w_data_out_nxt;
            r_ready    <= w_ready_nxt;
            r_active   <= (w_state_nxt == ST_ACTIVE);
`ifdef SERIAL_PARITY_EN
            r_parity   <= w_parity_nxt;
`endif
        end
    end

    // Next-state: byte selection on frame start, shifting on every other edge.
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_sync_cnt_nxt = r_sync_cnt;
        w_shift_nxt    = r_shift;
        w_data_out_nxt = r_data_out;
        w_ready_nxt    = 1'b0;
        w_byte         = IDLE_CHAR;
`ifdef SERIAL_PARITY_EN
        w_parity_nxt   = r_parity;
`endif

        if (r_bit_cnt == '0) begin
            if ((r_state == ST_SYNC) && (r_sync_cnt < SYNC_LIM)) begin
                w_byte         = COM_CHAR;
                w_sync_cnt_nxt = r_sync_cnt + CNT_W'(1);
            end else begin
                // Preamble done: this frame start already follows ACTIVE byte selection.
                w_state_nxt = ST_ACTIVE;
                if (valid_in) begin
                    w_byte      = data_in;
                    w_ready_nxt = 1'b1;
                end
            end
            w_data_out_nxt = w_byte[7];
            w_shift_nxt    = {w_byte[6:0], 1'b0};
            w_bit_cnt_nxt  = CNT_W'(1);
`ifdef SERIAL_PARITY_EN
            w_parity_nxt   = ^w_byte;
`endif
        end else begin
`ifdef SERIAL_PARITY_EN
            w_data_out_nxt = (r_bit_cnt == LAST_BIT) ? r_parity : r_shift[7];
`else
            w_data_out_nxt = r_shift[7];
`endif
            w_shift_nxt    = {r_shift[6:0], 1'b0};
            w_bit_cnt_nxt  = (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + CNT_W'(1);
        end
    end

    assign data_out  = r_data_out;
    assign ready_out = r_ready;
    assign active    = r_active;

endmodule

// File: tb/tb_serializador_tx.sv
// tb_serializador_tx: random and directed stimulus against a frame-position model of the serial stream.
// Builds with or without SERIAL_PARITY_EN; the model follows the same macro.
module tb_serializador_tx;

`ifdef SERIAL_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif
    localparam int         SYNC_COUNT = 4;
    localparam logic [7:0] COM        = 8'hBC;
    localparam logic [7:0] IDLE       = 8'h7C;

    logic       clk_8f;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       data_out;
    logic       ready_out;
    logic       active;

    serializador_tx #(
        .COM_CHAR  (COM),
        .IDLE_CHAR (IDLE),
        .SYNC_COUNT(SYNC_COUNT)
    ) dut (
        .clk_8f   (clk_8f),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .data_out (data_out),
        .ready_out(ready_out),
        .active   (active)
    );

    initial clk_8f = 1'b0;
    always #5 clk_8f = ~clk_8f;

    int n_err;
    int n_chk;

    // Model: position inside the current frame, frames sent since reset, current frame byte.
    int         m_pos;
    int         m_frames;
    logic [7:0] m_cur;
    logic       m_act;
    int         edge_no;
    int         first_act;
    int         last_rdy;
    int         n_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    // One clock edge: drive inputs, advance the model, compare all outputs on the falling edge.
    task automatic step(input logic rst_v, input logic vld, input logic [7:0] din);
        logic e_do;
        logic e_rdy;
        reset    = rst_v;
        valid_in = vld;
        data_in  = din;
        @(posedge clk_8f);
        e_do  = 1'b0;
        e_rdy = 1'b0;
        if (!rst_v) begin
            m_pos     = 0;
            m_frames  = 0;
            m_act     = 1'b0;
            edge_no   = 0;
            first_act = -1;
        end else begin
            edge_no++;
            if (m_pos == 0) begin
                if (m_frames < SYNC_COUNT) begin
                    m_cur = COM;
                    m_frames++;
                end else begin
                    m_act = 1'b1;
                    m_cur = vld ? din : IDLE;
                    e_rdy = vld;
                end
            end
            e_do  = (m_pos < 8) ? m_cur[7 - m_pos] : ^m_cur;
            m_pos = (m_pos + 1) % FL;
        end
        @(negedge clk_8f);
        chk("data_out", 32'(data_out), 32'(e_do));
        chk("ready_out", 32'(ready_out), 32'(e_rdy));
        chk("active", 32'(active), 32'(m_act));
        if (active && first_act < 0) first_act = edge_no;
        if (ready_out) begin
            last_rdy = edge_no;
            n_rdy++;
        end
    endtask

    // One whole frame; inputs offered only on the first edge, noise on the rest.
    task automatic send_frame(input logic vld, input logic [7:0] din, output logic [8:0] bits);
        bits = '0;
        for (int i = 0; i < FL; i++) begin
            if (i == 0) step(1'b1, vld, din);
            else        step(1'b1, 1'($urandom), 8'($urandom));
            bits = {bits[7:0], data_out};
        end
    endtask

    task automatic sync_preamble();
        logic [8:0] bits;
        for (int f = 0; f < SYNC_COUNT; f++) begin
            send_frame(1'b0, 8'($urandom), bits);
            chk("sync_frame", 32'(bits[7:0]), 32'(8'b10111100));
`ifdef SERIAL_PARITY_EN
            chk("sync_parity", 32'(bits), 32'(9'b101111001));
`endif
        end
    endtask

    initial begin
        logic [8:0] bits;
        int         r1;
        int         r2;
        n_err     = 0;
        n_chk     = 0;
        m_pos     = 0;
        m_frames  = 0;
        m_cur     = '0;
        m_act     = 1'b0;
        edge_no   = 0;
        first_act = -1;
        last_rdy  = -1;
        n_rdy     = 0;
        reset     = 1'b0;
        valid_in  = 1'b0;
        data_in   = '0;

        repeat (5) step(1'b0, 1'b1, 8'($urandom));
        chk("reset_active", 32'(active), 32'(0));

        sync_preamble();
        chk("active_before_end", 32'(active), 32'(0));
        send_frame(1'b0, 8'($urandom), bits);
        chk("first_idle", 32'(bits[7:0]), 32'(8'b01111100));
        chk("active_rise_edge", 32'(first_act), 32'(SYNC_COUNT * FL + 1));

        n_rdy = 0;
        send_frame(1'b1, 8'hA5, bits);
        chk("a5_bits", 32'(bits[7:0]), 32'(8'b10100101));
`ifdef SERIAL_PARITY_EN
        chk("a5_parity_frame", 32'(bits), 32'(9'b101001010));
`endif
        chk("a5_ready_count", 32'(n_rdy), 32'(1));
        chk("a5_ready_edge", 32'(last_rdy), 32'(edge_no - FL + 1));
        send_frame(1'b0, 8'h00, bits);
        chk("idle_after_a5", 32'(bits[7:0]), 32'(8'b01111100));

        send_frame(1'b1, 8'h01, bits);
        r1 = last_rdy;
        chk("b01_bits", 32'(bits[7:0]), 32'(8'b00000001));
`ifdef SERIAL_PARITY_EN
        chk("b01_parity_frame", 32'(bits), 32'(9'b000000011));
`endif
        send_frame(1'b1, 8'hFF, bits);
        r2 = last_rdy;
        chk("bff_bits", 32'(bits[7:0]), 32'(8'b11111111));
        chk("ready_spacing", 32'(r2 - r1), 32'(FL));

        repeat (40) send_frame(1'($urandom), 8'($urandom), bits);

        // Abort an ACTIVE frame at bit 4.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'($urandom));
        step(1'b0, 1'b1, 8'($urandom));
        chk("midreset_data", 32'(data_out), 32'(0));
        chk("midreset_active", 32'(active), 32'(0));
        sync_preamble();
        chk("restart_active_low", 32'(active), 32'(0));
        repeat (30) send_frame(1'($urandom), 8'($urandom), bits);

        // Random-length reset followed by streaming with valid held high.
        repeat (1 + ($urandom % 3)) step(1'b0, 1'($urandom), 8'($urandom));
        for (int i = 0; i < (SYNC_COUNT + 12) * FL; i++) step(1'b1, 1'b1, 8'($urandom));
        chk("stream_active", 32'(active), 32'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
